sr_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit, parametrised in operand width and bits retired per cycle. It sits beside `sr_alu` in `sr_cpu`. The CPU presents decoded operands and funct3, holds them stable while `stall` is high, and writes `result` back in the cycle `done` pulses. This replaces the single-cycle `*` path and drives the CPU's `mult_ext` (PC write-enable hold).

---
 rtl/sr_muldiv.sv | 160 ++++++++++++++++
 tb/tb_sr_muldiv.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sr_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// STEP bits retired per CALC cycle, with sign fix-up and special-case bypass.
module sr_muldiv #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned ITER = XLEN / STEP;
    localparam int unsigned CW   = $clog2(ITER + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

    stateT               state, stateNext;
    logic [CW-1:0]       cnt;
    logic [2:0]          opReg;
    logic                negRes;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     bReg;
    logic [XLEN:0]       rem;

    logic                aSigned, bSigned, signA, signB;
    logic [XLEN-1:0]     absA, absB;
    logic                divByZero, overflow, special, accept;
    logic [XLEN-1:0]     specialRes;
    logic [XLEN+STEP-1:0]   mulSum;
    logic [2*XLEN+STEP-1:0] mulWide;
    logic [XLEN:0]       divRem;
    logic [XLEN-1:0]     divQuo;
    logic [2*XLEN-1:0]   prodAdj;
    logic [XLEN-1:0]     quoAdj, remAdj, fixRes;

    // Operand decode, only meaningful while IDLE
    always_comb begin
        aSigned = 1'b0;
        bSigned = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                aSigned = 1'b1;
                bSigned = 1'b1;
            end
            3'b010:  aSigned = 1'b1;
            default: ;
        endcase
        signA      = aSigned & srcA[XLEN-1];
        signB      = bSigned & srcB[XLEN-1];
        absA       = signA ? -srcA : srcA;
        absB       = signB ? -srcB : srcB;
        divByZero  = op[2] & (srcB == '0);
        overflow   = op[2] & ~op[0] & (srcA == INT_MIN) & (srcB == '1);
        special    = divByZero | overflow;
        specialRes = divByZero ? (op[1] ? srcA : '1) : (op[1] ? '0 : srcA);
        accept     = (state == IDLE) & start & ~kill;
    end

    // One CALC step: STEP multiplier bits, or STEP quotient bits
    always_comb begin
        mulSum = {{STEP{1'b0}}, acc[2*XLEN-1:XLEN]};
        for (int unsigned i = 0; i < STEP; i++) begin
            if (acc[i])
                mulSum = mulSum + ({{STEP{1'b0}}, bReg} << i);
        end
        mulWide = {mulSum, acc[XLEN-1:0]};

        divRem = rem;
        divQuo = acc[XLEN-1:0];
        for (int unsigned i = 0; i < STEP; i++) begin
            divRem = {divRem[XLEN-1:0], divQuo[XLEN-1]};
            divQuo = {divQuo[XLEN-2:0], 1'b0};
            if (divRem >= {1'b0, bReg}) begin
                divRem    = divRem - {1'b0, bReg};
                divQuo[0] = 1'b1;
            end
        end
    end

    always_comb begin
        prodAdj = negRes ? -acc : acc;
        quoAdj  = negRes ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remAdj  = negRes ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        case (opReg)
            3'b000:                 fixRes = prodAdj[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fixRes = prodAdj[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fixRes = quoAdj;
            default:                fixRes = remAdj;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = special ? DONE : CALC;
            CALC:    if (cnt == CW'(1)) stateNext = FIX;
            FIX:     stateNext = DONE;
            default: stateNext = IDLE;
        endcase
        if (kill)
            stateNext = IDLE;
    end

    always_comb begin
        busy  = (state != IDLE);
        done  = (state == DONE);
        stall = start & ~done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            opReg  <= '0;
            negRes <= 1'b0;
            acc    <= '0;
            bReg   <= '0;
            rem    <= '0;
            result <= '0;
        end else if (accept) begin
            cnt    <= CW'(ITER);
            opReg  <= op;
            // Remainder follows the dividend; everything else follows signA^signB
            negRes <= (op[2] & op[1]) ? signA : (signA ^ signB);
            acc    <= {{XLEN{1'b0}}, absA};
            bReg   <= absB;
            rem    <= '0;
            if (special)
                result <= specialRes;
        end else if (!kill) begin
            if (state == CALC) begin
                cnt <= cnt - CW'(1);
                if (opReg[2]) begin
                    acc[XLEN-1:0] <= divQuo;
                    rem           <= divRem;
                end else begin
                    acc <= mulWide[2*XLEN+STEP-1:STEP];
                end
            end else if (state == FIX) begin
                result <= fixRes;
            end
        end
    end

endmodule

// File: tb/tb_sr_muldiv.sv
// Directed bench for sr_muldiv: one instance at STEP=1 and one at STEP=4,
// a vector table for results/latency plus kill, reset and back-to-back sequences.
module tb_sr_muldiv;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN   [2];
    logic        start  [2];
    logic [2:0]  op     [2];
    logic [31:0] srcA   [2];
    logic [31:0] srcB   [2];
    logic        kill   [2];
    logic        stall  [2];
    logic        busy   [2];
    logic        done   [2];
    logic [31:0] result [2];

    sr_muldiv #(.XLEN(32), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rstN[0]), .start(start[0]), .op(op[0]),
        .srcA(srcA[0]), .srcB(srcB[0]), .kill(kill[0]),
        .stall(stall[0]), .busy(busy[0]), .done(done[0]), .result(result[0])
    );

    sr_muldiv #(.XLEN(32), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rstN[1]), .start(start[1]), .op(op[1]),
        .srcA(srcA[1]), .srcB(srcB[1]), .kill(kill[1]),
        .stall(stall[1]), .busy(busy[1]), .done(done[1]), .result(result[1])
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vecT;

    localparam int NV = 16;
    vecT vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input bit d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (STEP=%0d): got %h expected %h", name, d ? 4 : 1, act, exp);
        end
    endtask

    task automatic runOp(input bit d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit keep, output logic [31:0] r, output int lat,
                         output int busyCnt, output bit stallOk);
        @(negedge clk);
        op[d]    = o;
        srcA[d]  = a;
        srcB[d]  = b;
        start[d] = 1'b1;
        #1;
        stallOk = (stall[d] === 1'b1);
        lat     = 0;
        busyCnt = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done[d] === 1'b1) break;
            if (busy[d] === 1'b1) busyCnt++;
            if (stall[d] !== 1'b1) stallOk = 1'b0;
        end
        if (stall[d] !== 1'b0) stallOk = 1'b0;
        r = result[d];
        if (!keep) start[d] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        int          lat, busyCnt, n, doneSeen;
        bit          stallOk;

        for (int i = 0; i < 2; i++) begin
            rstN[i] = 1'b0; start[i] = 1'b0; kill[i] = 1'b0;
            op[i] = '0; srcA[i] = '0; srcB[i] = '0;
        end

        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       1'b0};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        1'b0};
        vecs[8]  = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};
        vecs[9]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[10] = '{3'b111, 32'd5,        32'd0,        32'd5,        1'b1};
        vecs[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[13] = '{3'b011, 32'h00010000, 32'h00010000, 32'd1,        1'b0};
        vecs[14] = '{3'b100, 32'h80000000, 32'd2,        32'hC0000000, 1'b0};
        vecs[15] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0};

        // Reset state and combinational stall
        #7;
        for (int di = 0; di < 2; di++) begin
            bit d;
            d = 1'(di);
            check("reset busy", d, 32'(busy[d]), 32'd0);
            check("reset done", d, 32'(done[d]), 32'd0);
            check("reset result", d, result[d], 32'd0);
            start[d] = 1'b1;
            #1;
            check("reset stall follows start", d, 32'(stall[d]), 32'd1);
            start[d] = 1'b0;
            #1;
            check("reset stall low", d, 32'(stall[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rstN[0] = 1'b1;
        rstN[1] = 1'b1;
        @(posedge clk);
        #1;

        for (int di = 0; di < 2; di++) begin
            bit d;
            d = 1'(di);
            n = d ? 8 : 32;

            for (int v = 0; v < NV; v++) begin
                runOp(d, vecs[v].op, vecs[v].a, vecs[v].b, 1'b0, r, lat, busyCnt, stallOk);
                check($sformatf("vec%0d result", v), d, r, vecs[v].exp);
                check($sformatf("vec%0d latency", v), d, lat, vecs[v].special ? 1 : n + 2);
                check($sformatf("vec%0d busy cycles", v), d, busyCnt, vecs[v].special ? 0 : n + 1);
                check($sformatf("vec%0d stall window", v), d, 32'(stallOk), 32'd1);
            end

            // kill mid-CALC: no done, result keeps the last vector's value
            @(negedge clk);
            op[d] = 3'b101; srcA[d] = 32'd100; srcB[d] = 32'd7; start[d] = 1'b1;
            for (int c = 0; c < (d ? 5 : 10); c++) @(posedge clk);
            #1;
            check("kill busy before", d, 32'(busy[d]), 32'd1);
            kill[d]  = 1'b1;
            start[d] = 1'b0;
            @(posedge clk);
            #1;
            kill[d] = 1'b0;
            check("kill busy", d, 32'(busy[d]), 32'd0);
            check("kill done", d, 32'(done[d]), 32'd0);
            check("kill result", d, result[d], vecs[NV-1].exp);
            doneSeen = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (done[d] === 1'b1) doneSeen++;
            end
            check("kill no done later", d, doneSeen, 0);
            check("kill result later", d, result[d], vecs[NV-1].exp);

            // async reset mid-CALC
            @(negedge clk);
            op[d] = 3'b000; srcA[d] = 32'd7; srcB[d] = 32'hFFFFFFFD; start[d] = 1'b1;
            repeat (5) @(posedge clk);
            #2;
            rstN[d] = 1'b0;
            #1;
            check("rst busy", d, 32'(busy[d]), 32'd0);
            check("rst done", d, 32'(done[d]), 32'd0);
            check("rst result", d, result[d], 32'd0);
            start[d] = 1'b0;
            @(negedge clk);
            rstN[d] = 1'b1;
            @(posedge clk);
            #1;
            check("rst stays idle", d, 32'(busy[d]), 32'd0);

            // back-to-back: start held high across the done cycle
            runOp(d, 3'b000, 32'd7, 32'hFFFFFFFD, 1'b1, r, lat, busyCnt, stallOk);
            check("b2b mul result", d, r, 32'hFFFFFFEB);
            check("b2b mul latency", d, lat, n + 2);
            check("b2b idle gap busy", d, 32'(busy[d]), 32'd0);
            check("b2b idle gap stall", d, 32'(stall[d]), 32'd1);
            runOp(d, 3'b101, 32'd100, 32'd7, 1'b0, r, lat, busyCnt, stallOk);
            check("b2b divu result", d, r, 32'd14);
            check("b2b divu latency", d, lat, n + 2);
            check("b2b divu stall window", d, 32'(stallOk), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
